// File: rtl/cis_pkg.sv
// rtl/cis_pkg.sv - shared colour/state types, defaults and stream word layout for CIS line capture
package cis_pkg;

    localparam int CIS_DATA_W   = 12;
    localparam int CIS_LEAD_PIX = 16;
    localparam int CIS_ACT_PIX  = 2592;
    localparam int CIS_CNT_W    = 12;

    typedef enum logic [1:0] {
        COL_R = 2'd0,
        COL_G = 2'd1,
        COL_B = 2'd2
    } cis_color_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LEAD,
        ST_ACTIVE
    } cap_state_e;

    typedef struct packed {
        logic                  first;
        logic                  last;
        cis_color_e            color;
        logic [CIS_DATA_W-1:0] data;
    } cis_word_t;

endpackage

// File: rtl/cis_capture_fifo.sv
// rtl/cis_capture_fifo.sv - first-word-fall-through elastic FIFO between capture stage and output stream
module cis_capture_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_rd;
    logic             do_wr;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_rd   = rd_en & ~empty;
    // A read in the same cycle frees the slot, so a write to a full FIFO still lands.
    assign do_wr   = wr_en & (~full | do_rd);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/cis_line_capture.sv
// rtl/cis_line_capture.sv - frames CIS colour lines, tags active pixels, streams them out through a FIFO
// Optional dark-level subtraction from the lead-in samples: CIS_CAPTURE_DARK_SUB_EN
module cis_line_capture
    import cis_pkg::*;
#(
    parameter int DATA_W     = CIS_DATA_W,
    parameter int LEAD_PIX   = CIS_LEAD_PIX,
    parameter int ACT_PIX    = CIS_ACT_PIX,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              SI_TOGGLE,
    input  logic [1:0]        SI_CNT,
    input  logic [DATA_W-1:0] ADC_DATA,
    input  logic              ADC_VALID,
    input  logic              CLR_ERR,
    output logic [DATA_W-1:0] M_DATA,
    output logic [1:0]        M_COLOR,
    output logic              M_FIRST,
    output logic              M_LAST,
    output logic              M_VALID,
    input  logic              M_READY,
    output logic              OVERFLOW,
    output logic              TRUNC,
    output logic              BUSY
);

    typedef struct packed {
        logic              first;
        logic              last;
        cis_color_e        color;
        logic [DATA_W-1:0] data;
    } word_t;

    localparam int                 WORD_W    = $bits(word_t);
    localparam logic [CIS_CNT_W-1:0] LEAD_LAST = CIS_CNT_W'(LEAD_PIX - 1);
    localparam logic [CIS_CNT_W-1:0] LAST_IDX  = CIS_CNT_W'(ACT_PIX - 1);

    cap_state_e           state;
    cis_color_e           color;
    logic [CIS_CNT_W-1:0] pix_cnt;
    logic                 r_tog;
    logic                 start;
    logic                 stg_valid;
    word_t                stg_word;
    logic [DATA_W-1:0]    pix_val;
    logic                 trunc_set;
    logic                 ovf_set;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [WORD_W-1:0]    fifo_rd;
    word_t                out_word;

`ifdef CIS_CAPTURE_DARK_SUB_EN
    logic [DATA_W+3:0] dark_acc;
    logic [DATA_W+3:0] acc_next;
    logic [DATA_W-1:0] dark;

    assign acc_next = dark_acc + {4'b0000, ADC_DATA};
    assign pix_val  = (ADC_DATA > dark) ? (ADC_DATA - dark) : '0;
`else
    assign pix_val  = ADC_DATA;
`endif

    assign start     = SI_TOGGLE ^ r_tog;
    assign trunc_set = start & ((SI_CNT == 2'd3) | (state == ST_ACTIVE));
    assign ovf_set   = stg_valid & fifo_full & ~M_READY;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= ST_IDLE;
            color     <= COL_R;
            pix_cnt   <= '0;
            r_tog     <= 1'b0;
            stg_valid <= 1'b0;
            stg_word  <= '0;
            OVERFLOW  <= 1'b0;
            TRUNC     <= 1'b0;
`ifdef CIS_CAPTURE_DARK_SUB_EN
            dark_acc  <= '0;
            dark      <= '0;
`endif
        end else begin
            r_tog     <= SI_TOGGLE;
            stg_valid <= 1'b0;
            OVERFLOW  <= ovf_set | (OVERFLOW & ~CLR_ERR);
            TRUNC     <= trunc_set | (TRUNC & ~CLR_ERR);
            // A line start pre-empts any sample arriving in the same cycle.
            if (start) begin
                pix_cnt <= '0;
`ifdef CIS_CAPTURE_DARK_SUB_EN
                dark_acc <= '0;
`endif
                if (SI_CNT == 2'd3) begin
                    state <= ST_IDLE;
                end else begin
                    color <= cis_color_e'(SI_CNT);
                    state <= ST_LEAD;
                end
            end else if (ADC_VALID) begin
                case (state)
                    ST_LEAD: begin
`ifdef CIS_CAPTURE_DARK_SUB_EN
                        dark_acc <= acc_next;
`endif
                        if (pix_cnt == LEAD_LAST) begin
                            pix_cnt <= '0;
                            state   <= ST_ACTIVE;
`ifdef CIS_CAPTURE_DARK_SUB_EN
                            dark    <= acc_next[DATA_W+3:4];
`endif
                        end else begin
                            pix_cnt <= pix_cnt + CIS_CNT_W'(1);
                        end
                    end
                    ST_ACTIVE: begin
                        stg_valid      <= 1'b1;
                        stg_word.first <= (pix_cnt == '0);
                        stg_word.last  <= (pix_cnt == LAST_IDX);
                        stg_word.color <= color;
                        stg_word.data  <= pix_val;
                        // Counter parks on the last index, so it saturates there.
                        if (pix_cnt == LAST_IDX) state   <= ST_IDLE;
                        else                     pix_cnt <= pix_cnt + CIS_CNT_W'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    cis_capture_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .RST     (RST),
        .wr_en   (stg_valid),
        .wr_data (stg_word),
        .rd_en   (M_READY),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign out_word = fifo_empty ? '0 : word_t'(fifo_rd);
    assign M_VALID  = ~fifo_empty;
    assign M_DATA   = out_word.data;
    assign M_COLOR  = out_word.color;
    assign M_FIRST  = out_word.first;
    assign M_LAST   = out_word.last;
    assign BUSY     = (state != ST_IDLE);

endmodule
